// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (A)
// and load/store (B). Round-robin grant, bounded ownership lock for atomic
// sequences, registered read data with one-cycle latency.
module mem_arbiter #(
  parameter int unsigned LOCK_MAX = 8,
  parameter int unsigned WORD_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [WORD_W-1:0] a_addr,
  input  logic [WORD_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [WORD_W-1:0] b_addr,
  input  logic [WORD_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [WORD_W-1:0] a_rdata,
  output logic [WORD_W-1:0] b_rdata,
  output logic [WORD_W-1:0] mem_a,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wd,
  input  logic [WORD_W-1:0] mem_rd
);

  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  // prio: 0 = A wins a tie, 1 = B wins a tie
  logic [1:0] state, state_n;
  logic       prio, prio_n;
  logic [7:0] lock_cnt, cnt_n;
  logic       gnt_a, gnt_b;

  // Grant decision and next-state for arbitration, ownership and lock count
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    state_n = state;
    prio_n  = prio;
    cnt_n   = lock_cnt;
    case (state)
      ARB: begin
        if (a_req && (!b_req || !prio)) gnt_a = 1'b1;
        else if (b_req)                 gnt_b = 1'b1;
        if (gnt_a) begin
          prio_n = 1'b1;
          if (a_lock) begin
            state_n = OWN_A;
            cnt_n   = 8'd1;
          end
        end
        if (gnt_b) begin
          prio_n = 1'b0;
          if (b_lock) begin
            state_n = OWN_B;
            cnt_n   = 8'd1;
          end
        end
      end
      OWN_A: begin
        // Forced release pre-empts the owner's request in the same cycle
        if (lock_cnt == LOCK_LIM && b_req) begin
          state_n = ARB;
          prio_n  = 1'b1;
          cnt_n   = '0;
        end else if (a_req) begin
          gnt_a = 1'b1;
          if (a_lock) begin
            if (b_req) cnt_n = 8'(lock_cnt + 8'd1);
          end else begin
            state_n = ARB;
            prio_n  = 1'b1;
            cnt_n   = '0;
          end
        end else if (!a_lock) begin
          state_n = ARB;
          prio_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      OWN_B: begin
        if (lock_cnt == LOCK_LIM && a_req) begin
          state_n = ARB;
          prio_n  = 1'b0;
          cnt_n   = '0;
        end else if (b_req) begin
          gnt_b = 1'b1;
          if (b_lock) begin
            if (a_req) cnt_n = 8'(lock_cnt + 8'd1);
          end else begin
            state_n = ARB;
            prio_n  = 1'b0;
            cnt_n   = '0;
          end
        end else if (!b_lock) begin
          state_n = ARB;
          prio_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ARB;
        cnt_n   = '0;
      end
    endcase
  end

  // Grants are suppressed while reset is held so no access leaks out
  always_comb begin
    a_gnt  = gnt_a & rst_n;
    b_gnt  = gnt_b & rst_n;
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    if (a_gnt) begin
      mem_a  = a_addr;
      mem_we = a_we;
      mem_wd = a_wdata;
    end else if (b_gnt) begin
      mem_a  = b_addr;
      mem_we = b_we;
      mem_wd = b_wdata;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      prio     <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      prio     <= prio_n;
      lock_cnt <= cnt_n;
    end
  end

  // Capture read data for the granted reader; rvalid pulses one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata <= mem_rd;
      if (b_gnt && !b_we) b_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory behind it.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
  logic [31:0] a_rdata, b_rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [16];

  int tests;
  int fails;

  mem_arbiter #(.LOCK_MAX(4), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at end of grant cycle
  assign mem_rd = mem[mem_a[3:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[3:0]] <= mem_wd;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ea;
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_addr = 32'd8; b_addr = 32'd9; a_wdata = 32'hA0; b_wdata = 32'hB0;
    #2;
    if (a_gnt !== 1'b0) begin fails++; $display("FAIL rst_a_gnt: got %b want 0", a_gnt); end tests++;
    if (b_gnt !== 1'b0) begin fails++; $display("FAIL rst_b_gnt: got %b want 0", b_gnt); end tests++;
    if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end tests++;
    repeat (2) cyc();
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end tests++;
    if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h %h want 0 0", a_rdata, b_rdata); end tests++;
    if (a_gnt !== 1'b0) begin fails++; $display("FAIL rst_hold_a_gnt: got %b want 0", a_gnt); end tests++;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      ea = (i % 2 == 0);
      if (a_gnt !== ea) begin fails++; $display("FAIL rst_alt_a[%0d]: got %b want %b", i, a_gnt, ea); end tests++;
      if (b_gnt !== !ea) begin fails++; $display("FAIL rst_alt_b[%0d]: got %b want %b", i, b_gnt, !ea); end tests++;
      if (mem_wd !== (ea ? 32'hA0 : 32'hB0)) begin fails++; $display("FAIL rst_alt_wd[%0d]: got %h want %h", i, mem_wd, ea ? 32'hA0 : 32'hB0); end tests++;
      cyc();
    end
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic test_single_port();
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd3; b_wdata = 32'h5A;
    #1;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin fails++; $display("FAIL sp_wr_gnt: got a=%b b=%b want a=0 b=1", a_gnt, b_gnt); end tests++;
    if (mem_we !== 1'b1 || mem_a !== 32'd3 || mem_wd !== 32'h5A) begin fails++; $display("FAIL sp_wr_bus: got we=%b a=%h wd=%h want 1 3 5a", mem_we, mem_a, mem_wd); end tests++;
    cyc();
    if (b_rvalid !== 1'b0) begin fails++; $display("FAIL sp_wr_norvalid: got %b want 0", b_rvalid); end tests++;
    b_we = 1'b0;
    #1;
    if (b_gnt !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL sp_rd_gnt: got gnt=%b we=%b want 1 0", b_gnt, mem_we); end tests++;
    cyc();
    b_req = 1'b0;
    if (b_rvalid !== 1'b1) begin fails++; $display("FAIL sp_rd_rvalid: got %b want 1", b_rvalid); end tests++;
    if (b_rdata !== 32'h5A) begin fails++; $display("FAIL sp_rd_data: got %h want 5a", b_rdata); end tests++;
    if (a_rvalid !== 1'b0) begin fails++; $display("FAIL sp_a_rvalid: got %b want 0", a_rvalid); end tests++;
    cyc();
    if (b_rvalid !== 1'b0) begin fails++; $display("FAIL sp_rvalid_pulse: got %b want 0", b_rvalid); end tests++;
    if (b_rdata !== 32'h5A) begin fails++; $display("FAIL sp_rdata_hold: got %h want 5a", b_rdata); end tests++;
  endtask

  task automatic test_contention();
    // Preload through port A; prio ends pointing at B
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd1; a_wdata = 32'h11;
    #1;
    if (a_gnt !== 1'b1) begin fails++; $display("FAIL ct_pre1: got %b want 1", a_gnt); end tests++;
    cyc();
    a_addr = 32'd2; a_wdata = 32'h22;
    #1;
    if (a_gnt !== 1'b1) begin fails++; $display("FAIL ct_pre2: got %b want 1", a_gnt); end tests++;
    cyc();
    a_we = 1'b0; a_addr = 32'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
    #1;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_a !== 32'd2) begin fails++; $display("FAIL ct_first: got a=%b b=%b addr=%h want a=0 b=1 addr=2", a_gnt, b_gnt, mem_a); end tests++;
    cyc();
    b_req = 1'b0;
    #1;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_a !== 32'd1) begin fails++; $display("FAIL ct_second: got a=%b b=%b addr=%h want a=1 b=0 addr=1", a_gnt, b_gnt, mem_a); end tests++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h22) begin fails++; $display("FAIL ct_b_read: got v=%b d=%h want 1 22", b_rvalid, b_rdata); end tests++;
    if (a_rvalid !== 1'b0) begin fails++; $display("FAIL ct_a_early: got %b want 0", a_rvalid); end tests++;
    cyc();
    a_req = 1'b0;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h11) begin fails++; $display("FAIL ct_a_read: got v=%b d=%h want 1 11", a_rvalid, a_rdata); end tests++;
    if (b_rvalid !== 1'b0) begin fails++; $display("FAIL ct_b_pulse: got %b want 0", b_rvalid); end tests++;
  endtask

  task automatic test_lock();
    logic [31:0] exp_d [3];
    exp_d = '{32'h44, 32'h55, 32'h66};
    a_req = 1'b1; a_we = 1'b1; a_lock = 1'b1; a_addr = 32'd4; a_wdata = 32'h44;
    #1;
    if (a_gnt !== 1'b1 || mem_a !== 32'd4) begin fails++; $display("FAIL lk_first: got gnt=%b addr=%h want 1 4", a_gnt, mem_a); end tests++;
    cyc();
    // Owner idle but holding lock: B must not be granted
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd7; b_wdata = 32'h77;
    #1;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL lk_idle: got a=%b b=%b we=%b want 0 0 0", a_gnt, b_gnt, mem_we); end tests++;
    cyc();
    a_req = 1'b1; a_addr = 32'd5; a_wdata = 32'h55;
    #1;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_a !== 32'd5) begin fails++; $display("FAIL lk_second: got a=%b b=%b addr=%h want 1 0 5", a_gnt, b_gnt, mem_a); end tests++;
    cyc();
    a_addr = 32'd6; a_wdata = 32'h66; a_lock = 1'b0;
    #1;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin fails++; $display("FAIL lk_third: got a=%b b=%b want 1 0", a_gnt, b_gnt); end tests++;
    cyc();
    a_req = 1'b0;
    #1;
    if (b_gnt !== 1'b1 || mem_wd !== 32'h77) begin fails++; $display("FAIL lk_release: got b=%b wd=%h want 1 77", b_gnt, mem_wd); end tests++;
    cyc();
    b_req = 1'b0; b_we = 1'b0;
    // Back-to-back reads confirm the locked writes landed
    a_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_req = 1'b1; a_addr = 32'(4 + i);
      #1;
      if (a_gnt !== 1'b1) begin fails++; $display("FAIL lk_rd_gnt[%0d]: got %b want 1", i, a_gnt); end tests++;
      cyc();
      if (a_rvalid !== 1'b1 || a_rdata !== exp_d[i]) begin fails++; $display("FAIL lk_rd[%0d]: got v=%b d=%h want 1 %h", i, a_rvalid, a_rdata, exp_d[i]); end tests++;
    end
    a_req = 1'b0;
    cyc();
    if (a_rvalid !== 1'b0) begin fails++; $display("FAIL lk_rd_end: got %b want 0", a_rvalid); end tests++;
  endtask

  task automatic test_starvation();
    logic ea [6];
    logic eb [6];
    ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    eb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    a_req = 1'b1; a_we = 1'b1; a_lock = 1'b1; a_addr = 32'd10;
    b_we = 1'b1; b_addr = 32'd11; b_wdata = 32'hBB;
    for (int i = 0; i < 6; i++) begin
      a_wdata = 32'(i);
      b_req = (i >= 1);
      #1;
      if (a_gnt !== ea[i]) begin fails++; $display("FAIL sv_a[%0d]: got %b want %b", i, a_gnt, ea[i]); end tests++;
      if (b_gnt !== eb[i]) begin fails++; $display("FAIL sv_b[%0d]: got %b want %b", i, b_gnt, eb[i]); end tests++;
      if (mem_we !== (ea[i] | eb[i])) begin fails++; $display("FAIL sv_we[%0d]: got %b want %b", i, mem_we, ea[i] | eb[i]); end tests++;
      cyc();
    end
    b_req = 1'b0; a_lock = 1'b0;
    #1;
    if (a_gnt !== 1'b1) begin fails++; $display("FAIL sv_after: got %b want 1", a_gnt); end tests++;
    cyc();
    a_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd3;
    #1;
    if (b_gnt !== 1'b1) begin fails++; $display("FAIL mr_gnt: got %b want 1", b_gnt); end tests++;
    #2;
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    if (b_rdata !== 32'd0 || b_rvalid !== 1'b0) begin fails++; $display("FAIL mr_clear: got v=%b d=%h want 0 0", b_rvalid, b_rdata); end tests++;
    cyc();
    if (b_rvalid !== 1'b0) begin fails++; $display("FAIL mr_no_rvalid: got %b want 0", b_rvalid); end tests++;
    rst_n = 1'b1;
    cyc();
    if (b_rvalid !== 1'b0 || b_rdata !== 32'd0) begin fails++; $display("FAIL mr_after: got v=%b d=%h want 0 0", b_rvalid, b_rdata); end tests++;
    b_req = 1'b1;
    #1;
    if (b_gnt !== 1'b1) begin fails++; $display("FAIL mr_regnt: got %b want 1", b_gnt); end tests++;
    cyc();
    b_req = 1'b0;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h5A) begin fails++; $display("FAIL mr_mem_kept: got v=%b d=%h want 1 5a", b_rvalid, b_rdata); end tests++;
  endtask

  initial begin
    tests = 0; fails = 0;
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
    rst_n = 1'b0;
    test_reset();
    test_single_port();
    test_contention();
    test_lock();
    test_starvation();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
